pipe_stage_reg_skid: RTL and testbench

Parametrised pipeline stage register for the MIPS datapath; replaces fixed per-stage register bundles such as MEM/WB.
- Carries one beat: a control vector, a destination register index and a data payload.
- Adds a valid/ready handshake, a 2-entry skid buffer so that in_ready is a registered signal, a synchronous flush for hazard/branch squash, and a saturating stall-cycle counter.
- Sits between any two pipeline stages. The hazard unit drives flush; downstream stall logic drives out_ready.

---
 rtl/pipe_stage_reg_skid_pkg.sv | 14 +
 rtl/pipe_stage_reg_skid_if.sv | 34 +++
 rtl/pipe_stage_reg_skid_entry.sv | 40 ++++
 rtl/pipe_stage_reg_skid.sv | 142 ++++++++++++++
 tb/tb_pipe_stage_reg_skid.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_stage_reg_skid_pkg.sv
// Shared widths and occupancy encodings for the skid-buffered pipeline stage.
// Contents: default bus widths, occupancy field width and its three levels.
package pipe_pkg;

  localparam int unsigned DATA_W_DEF = 64;
  localparam int unsigned CTRL_W_DEF = 2;
  localparam int unsigned DEST_W_DEF = 5;

  localparam int unsigned OCC_W = 2;
  localparam logic [OCC_W-1:0] OCC_EMPTY = 2'd0;
  localparam logic [OCC_W-1:0] OCC_ONE   = 2'd1;
  localparam logic [OCC_W-1:0] OCC_FULL  = 2'd2;

endpackage

// File: rtl/pipe_stage_reg_skid_if.sv
// Upstream/downstream beat bus of a pipeline stage.
// master: producer/consumer side (drives in_* beat and out_ready).
// slave : the stage itself (drives in_ready and the out_* beat).
interface pipe_stage_reg_skid_if
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned DEST_W = DEST_W_DEF
) ();

  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DEST_W-1:0] in_dest;
  logic [DATA_W-1:0] in_data;

  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DEST_W-1:0] out_dest;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_ctrl, in_dest, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_dest, out_data
  );

  modport slave (
    input  in_valid, in_ctrl, in_dest, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_dest, out_data
  );

endinterface

// File: rtl/pipe_stage_reg_skid_entry.sv
// One held beat {valid, ctrl, dest, data}.
// Ports: clk/reset, load (capture d_*), clr (drop valid and ctrl; dest/data
// hold), d_* next beat, q_* held beat. clr wins over load.
module pipe_entry #(
  parameter int unsigned CTRL_W = 2,
  parameter int unsigned DEST_W = 5,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clr,
  input  logic              d_valid,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DEST_W-1:0] d_dest,
  input  logic [DATA_W-1:0] d_data,
  output logic              q_valid,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DEST_W-1:0] q_dest,
  output logic [DATA_W-1:0] q_data
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_valid <= 1'b0;
      q_ctrl  <= '0;
      q_dest  <= '0;
      q_data  <= '0;
    end else if (clr) begin
      q_valid <= 1'b0;
      q_ctrl  <= '0;
    end else if (load) begin
      q_valid <= d_valid;
      q_ctrl  <= d_ctrl;
      q_dest  <= d_dest;
      q_data  <= d_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg_skid.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid
// buffer, so in_ready is a flop with no path from out_ready.
// Ports: clk, reset (async, active-high), bus (slave side of the beat bus),
// flush (synchronous squash of all held beats), occupancy (beats held),
// cnt_clr (clear stall counter), stall_cnt (saturating stalled-cycle count).
module pipe_stage_reg_skid
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned DEST_W = DEST_W_DEF,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  pipe_stage_reg_skid_if.slave   bus,
  input  logic                   flush,
  output logic [OCC_W-1:0]       occupancy,
  input  logic                   cnt_clr,
  output logic [CNT_W-1:0]       stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DEST_W-1:0] main_dest, skid_dest;
  logic [DATA_W-1:0] main_data, skid_data;

  logic              main_load, main_clr, skid_load, skid_clr;
  logic              main_d_valid;
  logic [CTRL_W-1:0] main_d_ctrl;
  logic [DEST_W-1:0] main_d_dest;
  logic [DATA_W-1:0] main_d_data;
  logic              main_valid_nxt, skid_valid_nxt;
  logic              push, pop, main_advance;
  logic              in_ready_q;
  logic [OCC_W-1:0]  occupancy_q;
  logic [CNT_W-1:0]  stall_cnt_q;

  assign push         = bus.in_valid & in_ready_q;
  assign pop          = main_valid & bus.out_ready;
  assign main_advance = pop | ~main_valid;

  // Entry steering: flush, then skid->main, then input->main, then input->skid.
  always_comb begin
    main_load    = 1'b0;
    main_clr     = 1'b0;
    skid_load    = 1'b0;
    skid_clr     = 1'b0;
    main_d_valid = push;
    main_d_ctrl  = push ? bus.in_ctrl : '0;
    main_d_dest  = bus.in_dest;
    main_d_data  = bus.in_data;
    if (flush) begin
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else if (main_advance) begin
      main_load = 1'b1;
      if (skid_valid) begin
        main_d_valid = 1'b1;
        main_d_ctrl  = skid_ctrl;
        main_d_dest  = skid_dest;
        main_d_data  = skid_data;
        skid_clr     = 1'b1;
      end
    end else if (!skid_valid && push) begin
      skid_load = 1'b1;
    end
  end

  // Next valid bits, used to register in_ready and occupancy directly.
  always_comb begin
    main_valid_nxt = main_valid;
    skid_valid_nxt = skid_valid;
    if (main_clr)       main_valid_nxt = 1'b0;
    else if (main_load) main_valid_nxt = main_d_valid;
    if (skid_clr)       skid_valid_nxt = 1'b0;
    else if (skid_load) skid_valid_nxt = 1'b1;
  end

  pipe_entry #(.CTRL_W(CTRL_W), .DEST_W(DEST_W), .DATA_W(DATA_W)) u_main (
    .clk     (clk),
    .reset   (reset),
    .load    (main_load),
    .clr     (main_clr),
    .d_valid (main_d_valid),
    .d_ctrl  (main_d_ctrl),
    .d_dest  (main_d_dest),
    .d_data  (main_d_data),
    .q_valid (main_valid),
    .q_ctrl  (main_ctrl),
    .q_dest  (main_dest),
    .q_data  (main_data)
  );

  pipe_entry #(.CTRL_W(CTRL_W), .DEST_W(DEST_W), .DATA_W(DATA_W)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .load    (skid_load),
    .clr     (skid_clr),
    .d_valid (1'b1),
    .d_ctrl  (bus.in_ctrl),
    .d_dest  (bus.in_dest),
    .d_data  (bus.in_data),
    .q_valid (skid_valid),
    .q_ctrl  (skid_ctrl),
    .q_dest  (skid_dest),
    .q_data  (skid_data)
  );

  // Handshake status flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready_q  <= 1'b1;
      occupancy_q <= OCC_EMPTY;
    end else begin
      in_ready_q  <= ~skid_valid_nxt;
      occupancy_q <= OCC_W'(main_valid_nxt) + OCC_W'(skid_valid_nxt);
    end
  end

  // Saturating stall counter; clear wins over increment, flush has no effect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (cnt_clr) begin
      stall_cnt_q <= '0;
    end else if (main_valid && !bus.out_ready && stall_cnt_q != CNT_MAX) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = main_valid;
  assign bus.out_ctrl  = main_ctrl;
  assign bus.out_dest  = main_dest;
  assign bus.out_data  = main_data;
  assign occupancy     = occupancy_q;
  assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg_skid.sv
// Scoreboard bench for pipe_stage_reg_skid: accepted beats are queued as
// expected outputs, an independent monitor pops and compares on each pop.
module tb_pipe_stage_reg_skid;
  import pipe_pkg::*;

  typedef struct packed {
    logic [1:0]  c;
    logic [4:0]  d;
    logic [63:0] x;
  } beat_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0;
  logic       cnt_clr = 1'b0;
  logic [1:0] occupancy;
  logic [3:0] stall_cnt;

  int errors = 0;
  int checks = 0;
  int pop_cnt = 0;
  int cyc = 0;
  int stall_waits = 0;
  beat_t sb[$];

  pipe_stage_reg_skid_if #(.DATA_W(64), .CTRL_W(2), .DEST_W(5)) bus ();

  pipe_stage_reg_skid #(.DATA_W(64), .CTRL_W(2), .DEST_W(5), .CNT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .flush     (flush),
    .occupancy (occupancy),
    .cnt_clr   (cnt_clr),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present one beat until accepted; the accepted beat becomes an expectation.
  task automatic send(input logic [1:0] c, input logic [4:0] d, input logic [63:0] x);
    int  waits = 0;
    bit  done = 0;
    bus.in_valid = 1'b1;
    bus.in_ctrl  = c;
    bus.in_dest  = d;
    bus.in_data  = x;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back('{c: c, d: d, x: x});
        done = 1;
      end else begin
        waits++;
      end
      @(posedge clk); #1;
      if (!done && waits > 60) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: beat %0h not accepted after %0d cycles", x, waits);
        done = 1;
      end
    end
    bus.in_valid = 1'b0;
    stall_waits += waits;
  endtask

  // Monitor: compare every downstream pop against the scoreboard head.
  always @(negedge clk) begin
    if (!reset && !flush) begin
      if (!bus.out_valid) begin
        check("bubble_ctrl", 64'(bus.out_ctrl), 64'd0);
      end else if (bus.out_ready) begin
        pop_cnt++;
        if (sb.size() == 0) begin
          check("unexpected_beat", bus.out_data, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          beat_t e;
          e = sb.pop_front();
          check("pop_ctrl", 64'(bus.out_ctrl), 64'(e.c));
          check("pop_dest", 64'(bus.out_dest), 64'(e.d));
          check("pop_data", bus.out_data, e.x);
        end
      end
    end
  end

  initial begin
    int c0, p0;
    bus.in_valid  = 1'b0;
    bus.in_ctrl   = '0;
    bus.in_dest   = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Values while reset is held
    repeat (2) @(posedge clk); #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_ctrl", 64'(bus.out_ctrl), 64'd0);
    check("rst_out_dest", 64'(bus.out_dest), 64'd0);
    check("rst_out_data", bus.out_data, 64'd0);
    check("rst_occupancy", 64'(occupancy), 64'(OCC_EMPTY));
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    reset = 1'b0;

    // One-cycle latency from an empty stage
    bus.out_ready = 1'b1;
    send(2'b11, 5'd9, 64'hDEAD_BEEF_0000_0001);
    check("lat_out_valid", 64'(bus.out_valid), 64'd1);
    check("lat_out_ctrl", 64'(bus.out_ctrl), 64'd3);
    check("lat_out_dest", 64'(bus.out_dest), 64'd9);
    check("lat_occupancy", 64'(occupancy), 64'(OCC_ONE));
    @(posedge clk); #1;
    check("drain_occupancy", 64'(occupancy), 64'(OCC_EMPTY));

    // Full-rate stream of 8 beats
    c0 = cyc;
    p0 = pop_cnt;
    stall_waits = 0;
    for (int i = 1; i <= 8; i++) send(2'b01, 5'(i), 64'(i));
    check("stream_cycles", 64'(cyc - c0), 64'd8);
    check("stream_in_ready_waits", 64'(stall_waits), 64'd0);
    @(posedge clk); #1;
    check("stream_pops", 64'(pop_cnt - p0), 64'd8);
    check("stream_stall_cnt", 64'(stall_cnt), 64'd0);

    // Back-pressure: fill both entries, hold a third beat upstream
    bus.out_ready = 1'b0;
    send(2'b10, 5'd1, 64'hA);
    send(2'b01, 5'd2, 64'hB);
    check("full_occupancy", 64'(occupancy), 64'(OCC_FULL));
    check("full_in_ready", 64'(bus.in_ready), 64'd0);
    check("full_stall_cnt", 64'(stall_cnt), 64'd1);
    fork
      send(2'b11, 5'd3, 64'hC);
      begin
        repeat (3) @(posedge clk); #1;
        check("held_occupancy", 64'(occupancy), 64'(OCC_FULL));
        check("held_stall_cnt", 64'(stall_cnt), 64'd4);
        bus.out_ready = 1'b1;
      end
    join
    @(posedge clk); #1;
    check("bp_drained", 64'(occupancy), 64'(OCC_EMPTY));
    check("bp_stall_cnt", 64'(stall_cnt), 64'd4);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    check("clr_stall_cnt", 64'(stall_cnt), 64'd0);

    // Flush while full with a beat presented
    bus.out_ready = 1'b0;
    send(2'b11, 5'd4, 64'hD0);
    send(2'b11, 5'd5, 64'hE0);
    bus.in_valid = 1'b1;
    bus.in_ctrl  = 2'b11;
    bus.in_dest  = 5'd6;
    bus.in_data  = 64'hF0;
    flush = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_occupancy", 64'(occupancy), 64'(OCC_EMPTY));
    check("flush_out_valid", 64'(bus.out_valid), 64'd0);
    check("flush_out_ctrl", 64'(bus.out_ctrl), 64'd0);
    check("flush_in_ready", 64'(bus.in_ready), 64'd1);
    check("flush_data_held", bus.out_data, 64'hD0);
    check("flush_stall_cnt", 64'(stall_cnt), 64'd2);
    p0 = pop_cnt;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("flush_no_pops", 64'(pop_cnt - p0), 64'd0);

    // Stall counter saturation and clear priority
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    bus.out_ready = 1'b0;
    send(2'b01, 5'd7, 64'h77);
    repeat (20) @(posedge clk); #1;
    check("sat_stall_cnt", 64'(stall_cnt), 64'd15);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    check("clr_prio_stall_cnt", 64'(stall_cnt), 64'd0);
    cnt_clr = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_stall_cnt", 64'(stall_cnt), 64'd0);
    check("sat_drained", 64'(occupancy), 64'(OCC_EMPTY));

    // Asynchronous reset mid-cycle while full
    bus.out_ready = 1'b0;
    send(2'b11, 5'd8, 64'h88);
    send(2'b11, 5'd10, 64'h99);
    check("pre_rst_occupancy", 64'(occupancy), 64'(OCC_FULL));
    #2 reset = 1'b1;
    #1;
    check("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check("arst_out_ctrl", 64'(bus.out_ctrl), 64'd0);
    check("arst_occupancy", 64'(occupancy), 64'(OCC_EMPTY));
    check("arst_stall_cnt", 64'(stall_cnt), 64'd0);
    check("arst_in_ready", 64'(bus.in_ready), 64'd1);
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;

    // Stage still works after reset
    bus.out_ready = 1'b1;
    send(2'b10, 5'd11, 64'h1234_5678);
    @(posedge clk); #1;
    check("post_rst_drained", 64'(occupancy), 64'(OCC_EMPTY));
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
